// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_responder
// Description : Serial-ADC stand-in. Shifts a framed sample (external port or
//               internal ramp) onto sdo under control of an SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_responder #(
    parameter int DATA_BITS   = 10,
    parameter int LEAD_BITS   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int RAMP_STEP   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_clk,
    input  logic                 cs,
    output logic                 sdo,
    input  logic                 mode,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 frame_done,
    output logic                 underrun,
    output logic [15:0]          frame_count
);

    localparam int c_FRAME_BITS = LEAD_BITS + DATA_BITS;
    localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_LEAD_END = c_CNT_W'(LEAD_BITS);
    localparam logic [c_CNT_W-1:0] c_DATA_END = c_CNT_W'(c_FRAME_BITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LEAD = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_TAIL = 2'd3;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync;
    logic                   r_sclk_q, r_cs_q;
    logic                   r_sclk_fall, r_cs_fall, r_cs_rise;

    logic [1:0]             r_state, w_state_nxt;
    logic                   r_sdo, w_sdo_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic [c_CNT_W-1:0]     r_bit_cnt, w_cnt_nxt, w_cnt_inc;
    logic                   w_done;
    logic                   r_frame_done, r_underrun;
    logic [15:0]            r_frame_count;
    logic [DATA_BITS-1:0]   r_ramp, r_last, r_hold;
    logic                   r_hold_full;
    logic                   w_start, w_accept, w_underrun;
    logic [DATA_BITS-1:0]   w_sample;

    // Synchronizer chains idle at cs=1 / spi_clk=0 so reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_q    <= 1'b0;
            r_cs_q      <= 1'b1;
            r_sclk_fall <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
        end else begin
            r_sclk_sync[0] <= spi_clk;
            r_cs_sync[0]   <= cs;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
            end
            r_sclk_q    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_q      <= r_cs_sync[SYNC_STAGES-1];
            r_sclk_fall <= r_sclk_q & ~r_sclk_sync[SYNC_STAGES-1];
            r_cs_fall   <= r_cs_q & ~r_cs_sync[SYNC_STAGES-1];
            r_cs_rise   <= ~r_cs_q & r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_start      = (r_state == S_IDLE) && r_cs_fall;
    assign sample_ready = ~r_hold_full & ~mode;
    assign w_accept     = sample_valid & sample_ready;
    assign w_sample     = mode ? r_ramp : (r_hold_full ? r_hold : r_last);
    assign w_underrun   = w_start & ~mode & ~r_hold_full;
    assign w_cnt_inc    = r_bit_cnt + c_CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_cs_rise) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (r_cs_fall) w_state_nxt = (LEAD_BITS == 0) ? S_DATA : S_LEAD;
                S_LEAD: if (r_sclk_fall && w_cnt_inc == c_LEAD_END) w_state_nxt = S_DATA;
                S_DATA: if (r_sclk_fall && w_cnt_inc == c_DATA_END) w_state_nxt = S_TAIL;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Next sdo/shift/count values; sdo always shows the bit the master samples next.
    always_comb begin
        w_sdo_nxt   = r_sdo;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
        w_done      = 1'b0;
        if (r_cs_rise) begin
            w_sdo_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sdo_nxt = 1'b0;
                    if (r_cs_fall) begin
                        w_shift_nxt = w_sample;
                        w_cnt_nxt   = '0;
                        w_sdo_nxt   = (LEAD_BITS == 0) ? w_sample[DATA_BITS-1] : 1'b0;
                    end
                end
                S_LEAD: if (r_sclk_fall) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_sdo_nxt = (w_cnt_inc == c_LEAD_END) ? r_shift[DATA_BITS-1] : 1'b0;
                end
                S_DATA: if (r_sclk_fall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_DATA_END) begin
                        w_sdo_nxt = 1'b0;
                        w_done    = 1'b1;
                    end else begin
                        w_shift_nxt = {r_shift[DATA_BITS-2:0], 1'b0};
                        w_sdo_nxt   = r_shift[DATA_BITS-2];
                    end
                end
                default: w_sdo_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sdo         <= 1'b0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_frame_done  <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_count <= '0;
            r_ramp        <= '0;
            r_last        <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
        end else begin
            r_sdo        <= w_sdo_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_frame_done <= w_done;
            r_underrun   <= w_underrun;
            if (w_done)
                r_frame_count <= r_frame_count + 16'd1;
            if (w_start)
                r_last <= w_sample;
            if (w_start && mode)
                r_ramp <= r_ramp + DATA_BITS'(RAMP_STEP);
            // Start sees the pre-accept state; a same-cycle accept waits a frame.
            if (w_accept) begin
                r_hold      <= sample_in;
                r_hold_full <= 1'b1;
            end else if (w_start && !mode && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign sdo         = r_sdo;
    assign frame_done  = r_frame_done;
    assign underrun    = r_underrun;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
